window_ctrl: RTL and testbench

WINDOW_CTRL -- requirements
Module: window_ctrl

---
 rtl/window_ctrl_pkg.sv | 25 ++
 rtl/window_ctrl_raster_counter.sv | 89 ++++++++
 rtl/window_ctrl.sv | 155 +++++++++++++++
 tb/tb_window_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/window_ctrl_pkg.sv
// Shared definitions for the 3x3 window controller.
//   WORD_SIZE      : width of a threshold word
//   COORD_W        : width of the column/row coordinates
//   THRESH_DEFAULT : threshold loaded at reset unless overridden
//   state_t        : controller FSM encoding
//   in_frame()     : true in the states where pixels are accepted
package window_ctrl_pkg;

  localparam int WORD_SIZE = 8;
  localparam int COORD_W   = 11;

  localparam logic [WORD_SIZE-1:0] THRESH_DEFAULT = 8'd150;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic in_frame(input state_t s);
    return (s == ST_FILL) || (s == ST_ACTIVE);
  endfunction

endpackage

// File: rtl/window_ctrl_raster_counter.sv
// raster_counter: column/row position of the incoming pixel stream.
//   clk, reset : clock and synchronous active-high reset
//   clr        : frame restart; zeroes col and row
//   in_frame   : controller is in a pixel-accepting state
//   en, hsync  : pixel-valid qualifier and line-start pulse
//   accept     : the offered pixel is inside the active area
//   eff_col/row: coordinates the current pixel lands on (after any line start)
//   overrun    : sticky, a pixel was offered past WIDTH or HEIGHT
module raster_counter
  import window_ctrl_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               in_frame,
  input  logic               en,
  input  logic               hsync,
  output logic               accept,
  output logic [COORD_W-1:0] eff_col,
  output logic [COORD_W-1:0] eff_row,
  output logic               overrun
);

  localparam logic [COORD_W-1:0] WIDTH_C  = COORD_W'(WIDTH);
  localparam logic [COORD_W-1:0] HEIGHT_C = COORD_W'(HEIGHT);
  localparam logic [COORD_W-1:0] ONE_C    = COORD_W'(1);
  localparam logic [COORD_W-1:0] ZERO_C   = COORD_W'(0);

  logic [COORD_W-1:0] col_q, col_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic               overrun_q, overrun_d;
  logic               line_start_s;

  // Fold a line start into the coordinates so a pixel arriving with hsync lands on col 0 of the new row.
  always_comb begin
    line_start_s = hsync && in_frame;
    eff_col      = col_q;
    eff_row      = row_q;
    if (line_start_s) begin
      eff_col = ZERO_C;
      // Row saturates at HEIGHT so surplus line starts keep it out of range instead of wrapping.
      if (row_q < HEIGHT_C) begin
        eff_row = row_q + ONE_C;
      end else begin
        eff_row = row_q;
      end
    end else begin
      eff_col = col_q;
      eff_row = row_q;
    end
    accept = en && in_frame && (eff_col < WIDTH_C) && (eff_row < HEIGHT_C);
  end

  // Counter and overrun next-state; a frame restart wins over line and pixel events.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = ZERO_C;
      row_d = ZERO_C;
    end else if (accept) begin
      col_d = eff_col + ONE_C;
      row_d = eff_row;
    end else begin
      col_d = eff_col;
      row_d = eff_row;
    end
    overrun_d = overrun_q || (en && in_frame && !accept && !clr);
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q     <= ZERO_C;
      row_q     <= ZERO_C;
      overrun_q <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;

endmodule

// File: rtl/window_ctrl.sv
// window_ctrl: frame FSM and 3x3 window tracking for a raster pixel stream.
//   clk, reset    : clock and synchronous active-high reset
//   en            : pixel valid; hsync / vsync : line / frame start pulses
//   thresh_cfg    : threshold request, taken at frame start
//   shift_en      : line-buffer advance (combinational, equals pixel accept)
//   win_valid     : registered; 3x3 window centred at (cx, cy) complete
//   thresh_active : threshold in force for the current frame
//   frame_done    : pulse in the cycle after the last pixel
//   frame_abort   : pulse after vsync interrupts an unfinished frame
//   overrun       : sticky out-of-range pixel flag; busy : FSM not idle
module window_ctrl
  import window_ctrl_pkg::*;
#(
  parameter int                    WIDTH      = 640,
  parameter int                    HEIGHT     = 480,
  parameter logic [WORD_SIZE-1:0]  THRESH_RST = THRESH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 hsync,
  input  logic                 vsync,
  input  logic [WORD_SIZE-1:0] thresh_cfg,
  output logic                 shift_en,
  output logic                 win_valid,
  output logic [COORD_W-1:0]   cx,
  output logic [COORD_W-1:0]   cy,
  output logic [WORD_SIZE-1:0] thresh_active,
  output logic                 frame_done,
  output logic                 frame_abort,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [COORD_W-1:0] LAST_COL_C = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] LAST_ROW_C = COORD_W'(HEIGHT - 1);
  localparam logic [COORD_W-1:0] TWO_C      = COORD_W'(2);
  localparam logic [COORD_W-1:0] ONE_C      = COORD_W'(1);
  localparam logic [COORD_W-1:0] ZERO_C     = COORD_W'(0);

  state_t               state_q, state_d;
  logic                 in_frame_s, vsync_take_s, accept_s, count_s;
  logic [COORD_W-1:0]   eff_col_s, eff_row_s;
  logic                 win_valid_q, win_valid_d;
  logic [COORD_W-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic [WORD_SIZE-1:0] thresh_q, thresh_d;
  logic                 frame_done_q, frame_done_d;
  logic                 frame_abort_q, frame_abort_d;
  logic                 busy_q, busy_d;

  assign in_frame_s   = in_frame(state_q);
  // vsync is honoured everywhere except the one-cycle DONE state.
  assign vsync_take_s = vsync && (state_q != ST_DONE);
  // A pixel coinciding with a frame restart drives the line buffer but is not counted.
  assign count_s      = accept_s && !vsync_take_s;
  assign shift_en     = accept_s;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_raster (
    .clk      (clk),
    .reset    (reset),
    .clr      (vsync_take_s),
    .in_frame (in_frame_s),
    .en       (en),
    .hsync    (hsync),
    .accept   (accept_s),
    .eff_col  (eff_col_s),
    .eff_row  (eff_row_s),
    .overrun  (overrun)
  );

  // Frame FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (vsync) state_d = ST_FILL;
        else       state_d = ST_IDLE;
      end
      ST_FILL: begin
        if (vsync)                   state_d = ST_FILL;
        else if (eff_row_s == TWO_C) state_d = ST_ACTIVE;
        else                         state_d = ST_FILL;
      end
      ST_ACTIVE: begin
        if (vsync) begin
          state_d = ST_FILL;
        end else if (count_s && (eff_col_s == LAST_COL_C) && (eff_row_s == LAST_ROW_C)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Window, threshold and status output next-state.
  always_comb begin
    // The window centred one pixel up-left is complete once two rows and two columns precede it.
    win_valid_d = count_s && (eff_row_s >= TWO_C) && (eff_col_s >= TWO_C);
    cx_d        = cx_q;
    cy_d        = cy_q;
    if (win_valid_d) begin
      cx_d = eff_col_s - ONE_C;
      cy_d = eff_row_s - ONE_C;
    end else begin
      cx_d = cx_q;
      cy_d = cy_q;
    end
    if (vsync_take_s) begin
      thresh_d = thresh_cfg;
    end else begin
      thresh_d = thresh_q;
    end
    frame_done_d  = (state_d == ST_DONE);
    frame_abort_d = vsync && in_frame_s;
    busy_d        = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      win_valid_q   <= 1'b0;
      cx_q          <= ZERO_C;
      cy_q          <= ZERO_C;
      thresh_q      <= THRESH_RST;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_valid_q   <= win_valid_d;
      cx_q          <= cx_d;
      cy_q          <= cy_d;
      thresh_q      <= thresh_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
      busy_q        <= busy_d;
    end
  end

  assign win_valid     = win_valid_q;
  assign cx            = cx_q;
  assign cy            = cy_q;
  assign thresh_active = thresh_q;
  assign frame_done    = frame_done_q;
  assign frame_abort   = frame_abort_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_window_ctrl.sv
// Directed bench for window_ctrl with WIDTH=4, HEIGHT=3.
module tb_window_ctrl;
  import window_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, en, hsync, vsync;
  logic [7:0]  thresh_cfg;
  logic        shift_en, win_valid, frame_done, frame_abort, overrun, busy;
  logic [10:0] cx, cy;
  logic [7:0]  thresh_active;

  int errors = 0;
  int checks = 0;
  int wins   = 0;

  always #5 clk = ~clk;

  window_ctrl #(
    .WIDTH      (4),
    .HEIGHT     (3),
    .THRESH_RST (8'd150)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .hsync         (hsync),
    .vsync         (vsync),
    .thresh_cfg    (thresh_cfg),
    .shift_en      (shift_en),
    .win_valid     (win_valid),
    .cx            (cx),
    .cy            (cy),
    .thresh_active (thresh_active),
    .frame_done    (frame_done),
    .frame_abort   (frame_abort),
    .overrun       (overrun),
    .busy          (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; combinational outputs settle by the return.
  task automatic drive(input logic e, input logic h, input logic v);
    en = e; hsync = h; vsync = v;
    #1;
  endtask

  // Advance one clock; registered outputs are sampled 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (win_valid === 1'b1) wins++;
  endtask

  task automatic hs();
    drive(1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0);
    tick();
  endtask

  // One accepted pixel with the expected window/done response of that cycle.
  task automatic pix(input string tag, input logic exp_wv, input int ex, input int ey, input logic exp_fd);
    drive(1'b1, 1'b0, 1'b0);
    chk({tag, ".shift"}, 32'(shift_en), 32'd1);
    tick();
    chk({tag, ".wv"}, 32'(win_valid), 32'(exp_wv));
    if (exp_wv) begin
      chk({tag, ".cx"}, 32'(cx), 32'(ex));
      chk({tag, ".cy"}, 32'(cy), 32'(ey));
    end
    chk({tag, ".fd"}, 32'(frame_done), 32'(exp_fd));
  endtask

  task automatic row_nowin(input string tag);
    for (int i = 0; i < 4; i++) pix(tag, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".wv"},  32'(win_valid),     32'd0);
    chk({tag, ".cx"},  32'(cx),            32'd0);
    chk({tag, ".cy"},  32'(cy),            32'd0);
    chk({tag, ".fd"},  32'(frame_done),    32'd0);
    chk({tag, ".fa"},  32'(frame_abort),   32'd0);
    chk({tag, ".ov"},  32'(overrun),       32'd0);
    chk({tag, ".bz"},  32'(busy),          32'd0);
    chk({tag, ".th"},  32'(thresh_active), 32'd150);
    chk({tag, ".st"},  32'(dut.state_q),   32'(ST_IDLE));
    chk({tag, ".col"}, 32'(dut.u_raster.col_q), 32'd0);
    chk({tag, ".row"}, 32'(dut.u_raster.row_q), 32'd0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; hsync = 1'b0; vsync = 1'b0; thresh_cfg = 8'd150;
    tick();
    tick();

    // Reset state, with en high while reset holds
    drive(1'b1, 1'b0, 1'b0);
    chk("rst.shift", 32'(shift_en), 32'd0);
    tick();
    chk_reset_state("rst");
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    chk("idle.shift", 32'(shift_en), 32'd0);
    tick();
    chk("idle.ov", 32'(overrun), 32'd0);
    chk("idle.bz", 32'(busy), 32'd0);

    // Full frame
    drive(1'b0, 1'b0, 1'b1);
    tick();
    chk("f1.bz", 32'(busy), 32'd1);
    chk("f1.st", 32'(dut.state_q), 32'(ST_FILL));
    wins = 0;
    row_nowin("f1.r0");
    hs();
    row_nowin("f1.r1");
    hs();
    chk("f1.active", 32'(dut.state_q), 32'(ST_ACTIVE));
    pix("f1.r2c0", 1'b0, 0, 0, 1'b0);
    pix("f1.r2c1", 1'b0, 0, 0, 1'b0);
    pix("f1.r2c2", 1'b1, 1, 1, 1'b0);
    pix("f1.r2c3", 1'b1, 2, 1, 1'b1);
    chk("f1.bz_done", 32'(busy), 32'd1);
    idle();
    chk("f1.fd_end", 32'(frame_done), 32'd0);
    chk("f1.bz_end", 32'(busy), 32'd0);
    chk("f1.wv_end", 32'(win_valid), 32'd0);
    chk("f1.wins", 32'(wins), 32'd2);

    // Threshold shadow, then abort at row 1 col 2
    drive(1'b0, 1'b0, 1'b1);
    tick();
    thresh_cfg = 8'd90;
    row_nowin("f2.r0");
    hs();
    chk("f2.th_hold", 32'(thresh_active), 32'd150);
    pix("f2.r1c0", 1'b0, 0, 0, 1'b0);
    pix("f2.r1c1", 1'b0, 0, 0, 1'b0);
    chk("f2.col", 32'(dut.u_raster.col_q), 32'd2);
    chk("f2.row", 32'(dut.u_raster.row_q), 32'd1);
    chk("f2.th_hold2", 32'(thresh_active), 32'd150);
    drive(1'b0, 1'b0, 1'b1);
    tick();
    chk("ab.fa", 32'(frame_abort), 32'd1);
    chk("ab.th", 32'(thresh_active), 32'd90);
    chk("ab.col", 32'(dut.u_raster.col_q), 32'd0);
    chk("ab.row", 32'(dut.u_raster.row_q), 32'd0);
    chk("ab.st", 32'(dut.state_q), 32'(ST_FILL));
    chk("ab.bz", 32'(busy), 32'd1);
    chk("ab.fd", 32'(frame_done), 32'd0);
    idle();
    chk("ab.fa_once", 32'(frame_abort), 32'd0);
    chk("ab.fd2", 32'(frame_done), 32'd0);

    // Restarted frame with hsync and en together at the start of row 2
    wins = 0;
    row_nowin("f3.r0");
    hs();
    row_nowin("f3.r1");
    drive(1'b1, 1'b1, 1'b0);
    chk("f3.sim.shift", 32'(shift_en), 32'd1);
    tick();
    chk("f3.sim.wv", 32'(win_valid), 32'd0);
    chk("f3.sim.col", 32'(dut.u_raster.col_q), 32'd1);
    chk("f3.sim.row", 32'(dut.u_raster.row_q), 32'd2);
    chk("f3.sim.st", 32'(dut.state_q), 32'(ST_ACTIVE));
    pix("f3.r2c1", 1'b0, 0, 0, 1'b0);
    pix("f3.r2c2", 1'b1, 1, 1, 1'b0);
    pix("f3.r2c3", 1'b1, 2, 1, 1'b1);
    idle();
    chk("f3.wins", 32'(wins), 32'd2);
    chk("f3.ov", 32'(overrun), 32'd0);

    // Overrun: five pixels on row 0
    drive(1'b0, 1'b0, 1'b1);
    tick();
    chk("f4.th", 32'(thresh_active), 32'd90);
    row_nowin("f4.r0");
    chk("f4.ov_pre", 32'(overrun), 32'd0);
    drive(1'b1, 1'b0, 1'b0);
    chk("f4.shift5", 32'(shift_en), 32'd0);
    tick();
    chk("f4.ov", 32'(overrun), 32'd1);
    hs();
    row_nowin("f4.r1");
    chk("f4.ov_sticky", 32'(overrun), 32'd1);
    hs();
    pix("f4.r2c0", 1'b0, 0, 0, 1'b0);

    // Reset at row 2 col 1 with other inputs active
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1);
    tick();
    chk_reset_state("mrst");
    reset = 1'b0;
    idle();
    chk("mrst.fa", 32'(frame_abort), 32'd0);
    chk("mrst.fd", 32'(frame_done), 32'd0);
    chk("mrst.bz", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
